// File: rtl/booth_pkg.sv
// Shared types and default widths for the Booth multiplier datapath and its downstream stages.
package booth_pkg;

    localparam int unsigned OP_W       = 16;
    localparam int unsigned DEF_PROD_W = 2 * OP_W;
    localparam int unsigned DEF_ACC_W  = 40;
    localparam int unsigned DEF_CNT_W  = 8;

    typedef enum logic {
        ACCUM = 1'b0,
        HOLD  = 1'b1
    } acc_state_e;

endpackage

// File: rtl/acc_add_ovf.sv
// Sign-extending accumulator adder with two's-complement overflow detection.
module acc_add_ovf
    import booth_pkg::*;
#(
    parameter int unsigned ACC_W  = DEF_ACC_W,
    parameter int unsigned PROD_W = DEF_PROD_W
) (
    input  logic [ACC_W-1:0]  acc,
    input  logic [PROD_W-1:0] product,
    output logic [ACC_W-1:0]  sum,
    output logic              ovf
);

    logic [ACC_W-1:0] prod_ext;

    always_comb begin
        prod_ext = {{(ACC_W - PROD_W){product[PROD_W-1]}}, product};
        sum      = acc + prod_ext;
        // Overflow only when both operands share a sign the result does not.
        ovf      = (acc[ACC_W-1] == prod_ext[ACC_W-1]) && (sum[ACC_W-1] != acc[ACC_W-1]);
    end

endmodule

// File: rtl/booth_product_accumulator.sv
// Accumulates the signed Booth product stream into dot products and hands each sum downstream.
module booth_product_accumulator
    import booth_pkg::*;
#(
    parameter int unsigned PROD_W    = DEF_PROD_W,
    parameter int unsigned ACC_W     = DEF_ACC_W,
    parameter int unsigned CNT_W     = DEF_CNT_W,
    parameter int unsigned MAX_TERMS = 255
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              clr,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [PROD_W-1:0] in_product,
    input  logic              in_last,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [ACC_W-1:0]  out_sum,
    output logic [CNT_W-1:0]  out_count,
    output logic              out_ovf
);

    localparam logic [CNT_W-1:0] MAX_CNT = CNT_W'(MAX_TERMS);

    acc_state_e       state_q, state_d;
    logic [ACC_W-1:0] acc_q, acc_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             ovf_q, ovf_d;
    logic [ACC_W-1:0] out_sum_q, out_sum_d;
    logic [CNT_W-1:0] out_count_q, out_count_d;
    logic             out_ovf_q, out_ovf_d;

    logic [ACC_W-1:0] add_sum;
    logic             add_ovf;
    logic [CNT_W-1:0] cnt_inc;
    logic             new_ovf;
    logic             accept;
    logic             end_sum;

    acc_add_ovf #(
        .ACC_W  (ACC_W),
        .PROD_W (PROD_W)
    ) u_add (
        .acc     (acc_q),
        .product (in_product),
        .sum     (add_sum),
        .ovf     (add_ovf)
    );

    assign in_ready  = (state_q == ACCUM);
    assign out_valid = (state_q == HOLD);
    assign out_sum   = out_sum_q;
    assign out_count = out_count_q;
    assign out_ovf   = out_ovf_q;

    always_comb begin
        cnt_inc = cnt_q + CNT_W'(1);
        new_ovf = ovf_q | add_ovf;
        accept  = in_valid && in_ready && !clr;
        end_sum = accept && (in_last || (cnt_inc == MAX_CNT));
    end

    always_comb begin
        state_d     = state_q;
        acc_d       = acc_q;
        cnt_d       = cnt_q;
        ovf_d       = ovf_q;
        out_sum_d   = out_sum_q;
        out_count_d = out_count_q;
        out_ovf_d   = out_ovf_q;

        if (clr) begin
            // Abort wins over both an accept and a downstream transfer.
            state_d     = ACCUM;
            acc_d       = '0;
            cnt_d       = '0;
            ovf_d       = 1'b0;
            out_sum_d   = '0;
            out_count_d = '0;
            out_ovf_d   = 1'b0;
        end else begin
            unique case (state_q)
                ACCUM: begin
                    if (accept) begin
                        acc_d = add_sum;
                        cnt_d = cnt_inc;
                        ovf_d = new_ovf;
                        if (end_sum) begin
                            out_sum_d   = add_sum;
                            out_count_d = cnt_inc;
                            out_ovf_d   = new_ovf;
                            state_d     = HOLD;
                        end
                    end
                end
                HOLD: begin
                    if (out_ready) begin
                        state_d = ACCUM;
                        acc_d   = '0;
                        cnt_d   = '0;
                        ovf_d   = 1'b0;
                    end
                end
                default: state_d = ACCUM;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= ACCUM;
            acc_q       <= '0;
            cnt_q       <= '0;
            ovf_q       <= 1'b0;
            out_sum_q   <= '0;
            out_count_q <= '0;
            out_ovf_q   <= 1'b0;
        end else begin
            state_q     <= state_d;
            acc_q       <= acc_d;
            cnt_q       <= cnt_d;
            ovf_q       <= ovf_d;
            out_sum_q   <= out_sum_d;
            out_count_q <= out_count_d;
            out_ovf_q   <= out_ovf_d;
        end
    end

endmodule

// File: tb/tb_booth_product_accumulator.sv
// Directed bench: default, 33-bit-accumulator and 4-term-limit instances share clock and stimulus.
module tb_booth_product_accumulator;

    logic        clk;
    logic        rst_n;
    logic        clr;
    logic [2:0]  in_valid;
    logic [2:0]  in_ready;
    logic [31:0] in_product;
    logic        in_last;
    logic [2:0]  out_valid;
    logic        out_ready;
    logic [39:0] sum0;
    logic [32:0] sum1;
    logic [39:0] sum2;
    logic [7:0]  cnt0, cnt1, cnt2;
    logic [2:0]  ovf;

    int checks = 0;
    int errors = 0;

    booth_product_accumulator u_def (
        .clk (clk), .rst_n (rst_n), .clr (clr),
        .in_valid (in_valid[0]), .in_ready (in_ready[0]),
        .in_product (in_product), .in_last (in_last),
        .out_valid (out_valid[0]), .out_ready (out_ready),
        .out_sum (sum0), .out_count (cnt0), .out_ovf (ovf[0])
    );

    booth_product_accumulator #(.ACC_W (33)) u_narrow (
        .clk (clk), .rst_n (rst_n), .clr (clr),
        .in_valid (in_valid[1]), .in_ready (in_ready[1]),
        .in_product (in_product), .in_last (in_last),
        .out_valid (out_valid[1]), .out_ready (out_ready),
        .out_sum (sum1), .out_count (cnt1), .out_ovf (ovf[1])
    );

    booth_product_accumulator #(.MAX_TERMS (4)) u_lim (
        .clk (clk), .rst_n (rst_n), .clr (clr),
        .in_valid (in_valid[2]), .in_ready (in_ready[2]),
        .in_product (in_product), .in_last (in_last),
        .out_valid (out_valid[2]), .out_ready (out_ready),
        .out_sum (sum2), .out_count (cnt2), .out_ovf (ovf[2])
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp)
        else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // One-cycle offer of a product to instance sel.
    task automatic push(input int sel, input logic [31:0] p, input logic last);
        in_valid[sel] = 1'b1;
        in_product    = p;
        in_last       = last;
        step();
        in_valid[sel] = 1'b0;
        in_last       = 1'b0;
    endtask

    task automatic drain();
        out_ready = 1'b1;
        step();
        out_ready = 1'b0;
    endtask

    initial begin
        rst_n      = 1'b0;
        clr        = 1'b0;
        in_valid   = '0;
        in_product = '0;
        in_last    = 1'b0;
        out_ready  = 1'b0;
        #1;
        chk("rst_valid", 64'(out_valid), 64'd0);
        chk("rst_ready", 64'(in_ready), 64'h7);
        chk("rst_sum", 64'(sum0), 64'd0);
        chk("rst_count", 64'(cnt0), 64'd0);
        repeat (2) @(posedge clk);
        #1;
        rst_n = 1'b1;
        step();

        // Basic three-term dot product.
        push(0, 32'd2000000, 1'b0);
        push(0, 32'd12000000, 1'b0);
        chk("dot_valid_early", 64'(out_valid[0]), 64'd0);
        push(0, 32'd30000000, 1'b1);
        chk("dot_valid", 64'(out_valid[0]), 64'd1);
        chk("dot_sum", 64'(sum0), 64'd44000000);
        chk("dot_count", 64'(cnt0), 64'd3);
        chk("dot_ovf", 64'(ovf[0]), 64'd0);

        // Backpressure: held result, upstream keeps offering.
        in_valid[0] = 1'b1;
        in_product  = 32'd99;
        for (int i = 0; i < 5; i++) begin
            step();
            chk("bp_ready", 64'(in_ready[0]), 64'd0);
            chk("bp_sum", 64'(sum0), 64'd44000000);
            chk("bp_count", 64'(cnt0), 64'd3);
        end
        out_ready = 1'b1;
        step();
        out_ready   = 1'b0;
        in_product  = 32'd5;
        in_last     = 1'b1;
        chk("bp_release_valid", 64'(out_valid[0]), 64'd0);
        chk("bp_release_ready", 64'(in_ready[0]), 64'd1);
        step();
        in_valid[0] = 1'b0;
        in_last     = 1'b0;
        chk("bp_next_sum", 64'(sum0), 64'd5);
        chk("bp_next_count", 64'(cnt0), 64'd1);
        drain();

        // -1 then +1 cancels without overflow.
        push(0, 32'hFFFF_FFFF, 1'b0);
        push(0, 32'd1, 1'b1);
        chk("neg_sum", 64'(sum0), 64'd0);
        chk("neg_ovf", 64'(ovf[0]), 64'd0);
        chk("neg_count", 64'(cnt0), 64'd2);
        drain();

        // 33-bit accumulator overflows and wraps.
        push(1, 32'h7FFF_FFFF, 1'b0);
        push(1, 32'h7FFF_FFFF, 1'b0);
        push(1, 32'd2, 1'b1);
        chk("ovf_valid", 64'(out_valid[1]), 64'd1);
        chk("ovf_flag", 64'(ovf[1]), 64'd1);
        chk("ovf_sum", 64'(sum1), 64'h1_0000_0000);
        chk("ovf_count", 64'(cnt1), 64'd3);
        drain();

        // Term limit of 4 closes the sum without in_last.
        for (int i = 0; i < 4; i++) push(2, 32'd1, 1'b0);
        chk("lim_valid", 64'(out_valid[2]), 64'd1);
        chk("lim_sum", 64'(sum2), 64'd4);
        chk("lim_count", 64'(cnt2), 64'd4);
        push(2, 32'd1, 1'b0);
        chk("lim_blocked_sum", 64'(sum2), 64'd4);
        drain();
        push(2, 32'd1, 1'b0);
        push(2, 32'd1, 1'b1);
        chk("lim_next_sum", 64'(sum2), 64'd2);
        chk("lim_next_count", 64'(cnt2), 64'd2);
        drain();

        // clr discards the partial sum and the term accepted with it.
        push(0, 32'd4, 1'b0);
        push(0, 32'd6, 1'b0);
        clr = 1'b1;
        push(0, 32'd7, 1'b0);
        clr = 1'b0;
        push(0, 32'd3, 1'b0);
        push(0, 32'd5, 1'b1);
        chk("clr_sum", 64'(sum0), 64'd8);
        chk("clr_count", 64'(cnt0), 64'd2);
        drain();

        // clr during HOLD drops the result even with out_ready.
        push(0, 32'd9, 1'b1);
        chk("clrh_pre_valid", 64'(out_valid[0]), 64'd1);
        clr       = 1'b1;
        out_ready = 1'b1;
        step();
        clr       = 1'b0;
        out_ready = 1'b0;
        chk("clrh_valid", 64'(out_valid[0]), 64'd0);
        chk("clrh_ready", 64'(in_ready[0]), 64'd1);
        push(0, 32'd1, 1'b1);
        chk("clrh_next_sum", 64'(sum0), 64'd1);
        chk("clrh_next_count", 64'(cnt0), 64'd1);

        // Asynchronous reset while a result is held.
        #2;
        rst_n = 1'b0;
        #1;
        chk("arst_valid", 64'(out_valid[0]), 64'd0);
        chk("arst_sum", 64'(sum0), 64'd0);
        chk("arst_count", 64'(cnt0), 64'd0);
        chk("arst_ready", 64'(in_ready[0]), 64'd1);
        step();
        rst_n = 1'b1;
        step();
        chk("arst_post_valid", 64'(out_valid[0]), 64'd0);
        chk("arst_post_sum", 64'(sum0), 64'd0);
        chk("arst_post_ready", 64'(in_ready[0]), 64'd1);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/booth_product_accumulator.md
Name: booth_product_accumulator

Overview:
Downstream stage of the 16-bit Booth multiplier. Consumes its 32-bit signed product stream through a valid/ready handshake and accumulates products into a wide accumulator, forming dot products. On the last term, or when the term limit is reached, it presents the sum, term count and overflow flag on an output handshake. While a result is pending, it stalls the multiplier feed.

Parameters:
PROD_W, 32, product width (multiplier result, two's complement)
ACC_W, 40, accumulator/sum width; must be > PROD_W
CNT_W, 8, term counter width
MAX_TERMS, 255, terms after which the block ends the sum as if in_last was set; range 1 .. 2^CNT_W-1

Ports:
clk  input  1  single clock, rising edge
rst_n  input  1  asynchronous active-low reset
clr  input  1  synchronous abort: discard partial/pending sum
in_valid  input  1  product valid
in_ready  output  1  block can accept a product
in_product  input  PROD_W  signed product from BoothMultiplier
in_last  input  1  final term of current dot product
out_valid  output  1  sum valid
out_ready  input  1  consumer accepts sum
out_sum  output  ACC_W  signed accumulated sum
out_count  output  CNT_W  number of terms in out_sum
out_ovf  output  1  signed overflow occurred in this sum (sticky)

Behaviour:
- Clocking: one clock. Reset is asynchronous and active-low (rst_n). All state is in clk flops.
- States: ACCUM, HOLD. Reset puts the block in ACCUM with acc=0, cnt=0, ovf=0, out_valid=0, out_sum=0, out_count=0, out_ovf=0. in_ready is combinational: 1 in ACCUM, 0 in HOLD.
- ACCUM, on accept (in_valid & in_ready & !clr):
  - acc <= acc + sext(in_product) in ACC_W bits, wrapping.
  - cnt <= cnt+1.
  - ovf <= ovf | signed_overflow, where signed overflow means both operands have the same sign and the result sign differs.
- End of sum: the accept cycle in which in_last=1 or cnt+1 == MAX_TERMS.
  - Register out_sum = new acc, out_count = cnt+1, out_ovf = new ovf.
  - Enter HOLD with out_valid=1 on the next cycle. Latency from last accept to out_valid is one cycle.
- HOLD:
  - out_valid=1. out_sum, out_count and out_ovf stay stable until the transfer.
  - On out_ready: out_valid<=0; acc, cnt and ovf clear; return to ACCUM. in_ready rises the following cycle (no same-cycle bypass).
- in_valid while in_ready=0: ignored. The upstream must hold its data.
- clr: highest priority in any state. Next cycle: ACCUM, acc=cnt=ovf=0, out_valid=0, any pending result dropped.
  - clr with an accept in the same cycle: the term is discarded.
  - clr with out_ready in HOLD: the result counts as not delivered.
- in_valid=0 in ACCUM: state is held. There is no timeout.
- MAX_TERMS=1: every accepted product becomes a one-term sum.
- Reset mid-sum or in HOLD: all outputs return to their reset values immediately (asynchronous).

Decomposition:
- Shared package (booth_pkg): state enum {ACCUM, HOLD}, default widths PROD_W=32, ACC_W=40, CNT_W=8. The same package also holds the multiplier operand width of 16.
- One sub-module, acc_add_ovf: combinational ACC_W sign-extending adder.
  - Inputs: acc, product.
  - Outputs: sum, ovf.
  - Reusable by a future MAC stage.

Test Plan:
- Reset/idle: assert rst_n=0 mid-run with out_valid=1 -> out_valid=0, out_sum=0, out_count=0 and in_ready=1 within the reset cycle; they stay so after release.
- Basic dot product: products 1000*2000, 3000*4000, 5000*6000 (2,000,000; 12,000,000; 30,000,000), last on the third -> out_sum=44,000,000, out_count=3, out_ovf=0, out_valid exactly one cycle after the third accept.
- Backpressure: hold out_ready=0 for 5 cycles while driving in_valid=1 -> in_ready=0 throughout, sum stable, no extra term absorbed; on out_ready=1, in_ready returns the next cycle and the next sum starts from 0.
- Signed/overflow: with ACC_W=33, feed 0x7FFFFFFF twice then 0x00000002 (last) -> out_ovf=1, out_sum wraps to 0x1_0000_0000 (33-bit), out_count=3.
  - With default ACC_W=40: feed -1 (0xFFFFFFFF) then +1 -> out_sum=0, out_ovf=0.
- MAX_TERMS limit: MAX_TERMS=4, stream 6 products of 1 with no in_last -> first sum is 4, out_count=4; after the drain, the next 2 accumulate with the 2nd as last -> sum 2.
- clr priority: clr in the same cycle as an accepted product 7 after prior terms totalling 10, then products 3, 5 (last) -> out_sum=8, out_count=2.
  - clr during HOLD -> out_valid drops and no transfer is counted.
